muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Sequences the shared multicycle Mult and Div units on behalf of the control unit. Latches one request and its operands, and issues a single-cycle start pulse to the selected unit. Waits for that unit's end handshake, then commits the result to HI/LO through the hi/lo write enables and the div/mult result select. Screens divide-by-zero before starting the divider, so the control unit only sees a clean done or exception pulse.

Parameters:
DATA_W, 32, operand and result width
TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with MULDIV_TIMEOUT_EN)
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  request from control unit, sampled only when ready=1
op_sel  in  1  0=DIV, 1=MULT (same encoding as div_or_mult)
a_in  in  DATA_W  operand A (dividend / multiplicand)
b_in  in  DATA_W  operand B (divisor / multiplier)
ready  out  1  1 only in IDLE
op_a  out  DATA_W  latched operand A, drives unit inputs
op_b  out  DATA_W  latched operand B, drives unit inputs
mult_start  out  1  one-cycle start pulse to Mult
div_start  out  1  one-cycle start pulse to Div
mult_end  in  1  Mult completion
div_end  in  1  Div completion
div_0_exception  in  1  divider's own zero-divisor flag
div_or_mult  out  1  HI/LO source select, equals the latched op
high_write  out  1  HI load enable
low_write  out  1  LO load enable
done  out  1  one-cycle pulse on a successful commit
div0_exc  out  1  one-cycle pulse on divide-by-zero
timeout  out  1  one-cycle pulse on watchdog expiry (0 without macro)

Behaviour:
- Reset: state=IDLE. op_a, op_b, latched op, and watchdog counter cleared to 0. All pulse and write outputs 0. ready=1.
- States: IDLE, START, WAIT, COMMIT, EXC.
- IDLE:
  - On req=1, latch op_sel, a_in and b_in.
  - If op_sel=DIV and b_in==0, go to EXC. No div_start is ever issued.
  - Otherwise go to START.
- START: assert exactly one start line for one cycle (mult_start if op=MULT, else div_start), clear counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - The end signal of the selected unit goes to COMMIT.
  - The other unit's end signal is ignored.
  - div_0_exception=1 while op=DIV goes to EXC, with priority over div_end in the same cycle.
- COMMIT: high_write=low_write=done=1 for exactly one cycle; div_or_mult held at the op; next IDLE.
- EXC: div0_exc=1 (or timeout=1 for a watchdog exit) for one cycle; no HI/LO write; next IDLE.
- div_or_mult: driven from the latched op in every state, so the HI/LO mux input is stable before COMMIT.
- Latency:
  - req in cycle N: start in N+1, WAIT from N+2.
  - End in cycle E: COMMIT in E+1, ready=1 again in E+2.
  - Div-by-zero: EXC in N+1.
- req while ready=0 is ignored, not queued; the control unit must hold or re-issue it.
- op_a and op_b only change in IDLE on an accepted request. They stay stable for the unit's whole operation, even if A/B registers change.
- Reset mid-operation returns to IDLE next edge. Start and write outputs deassert, and no done is produced. Mult and Div share the same reset.

Optional Feature:
MULDIV_TIMEOUT_EN
- Defined: if the counter reaches TIMEOUT_CYCLES in WAIT with no end signal, go to EXC with timeout=1. An end signal arriving in the same cycle wins and goes to COMMIT.
- Undefined: no counter logic, WAIT is unbounded, timeout tied to 0.

Decomposition:
- Package muldiv_pkg:
  - state enum (IDLE, START, WAIT, COMMIT, EXC)
  - OP_DIV=1'b0, OP_MULT=1'b1
  - default TIMEOUT_CYCLES
- Sub-module muldiv_watchdog: counter with clear, enable and expire outputs. It is instantiated only under MULDIV_TIMEOUT_EN.

Test Plan:
- MULT 7 x 6 with model end 34 cycles after start -> one mult_start pulse only; COMMIT with div_or_mult=1; HI=0, LO=42; done one cycle; ready back 2 cycles after end.
- DIV 17 / 5 -> one div_start pulse only; COMMIT with div_or_mult=0; LO=3, HI=2; mult_end pulsed mid-WAIT is ignored.
- DIV 9 / 0 -> div0_exc in cycle N+1; no div_start, high_write or low_write; ready=1 in N+2.
- req re-asserted every cycle during WAIT with a_in=99 -> ignored; op_a unchanged; exactly one done.
- reset asserted in WAIT -> IDLE next edge; all outputs at reset values; no done or write.
- With MULDIV_TIMEOUT_EN and TIMEOUT_CYCLES=8, end never asserted -> timeout pulse after 8 WAIT cycles; no HI/LO write. Repeat with end on cycle 8 -> COMMIT wins.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the Mult/Div sequencer slice.
// Optional watchdog support is enabled with MULDIV_TIMEOUT_EN.
package muldiv_pkg;

    localparam int DEFAULT_DATA_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 7;

    // Same encoding the HI/LO source mux uses for div_or_mult.
    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_COMMIT = 3'd3;
    localparam state_t S_EXC    = 3'd4;

    function automatic logic is_div_by_zero(input logic op, input logic b_is_zero);
        return (op == OP_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the sequencer, the control unit and the shared Mult/Div units.
// The timeout line is only ever driven high when built with MULDIV_TIMEOUT_EN.
interface muldiv_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              op_sel;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mult_start;
    logic              div_start;
    logic              mult_end;
    logic              div_end;
    logic              div_0_exception;
    logic              div_or_mult;
    logic              high_write;
    logic              low_write;
    logic              done;
    logic              div0_exc;
    logic              timeout;

    // Sequencer side.
    modport slave (
        input  req, op_sel, a_in, b_in, mult_end, div_end, div_0_exception,
        output ready, op_a, op_b, mult_start, div_start, div_or_mult,
               high_write, low_write, done, div0_exc, timeout
    );

    // Control unit and arithmetic units side.
    modport master (
        output req, op_sel, a_in, b_in, mult_end, div_end, div_0_exception,
        input  ready, op_a, op_b, mult_start, div_start, div_or_mult,
               high_write, low_write, done, div0_exc, timeout
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog counter; instantiated only when MULDIV_TIMEOUT_EN is defined.
// CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES and TIMEOUT_CYCLES >= 1.
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires in the cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multicycle Mult and Div units and commits results to HI/LO.
// Define MULDIV_TIMEOUT_EN to add a watchdog on the WAIT state.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_sequencer_if.slave  bus
);

    state_t            state_q;
    state_t            state_d;
    logic              op_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              sel_end;
    logic              accept;

`ifdef MULDIV_TIMEOUT_EN
    logic wd_expire;
    logic to_timeout;
    logic exc_timeout_q;

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q == S_START),
        .enable (state_q == S_WAIT),
        .expire (wd_expire)
    );
`endif

    assign accept  = (state_q == S_IDLE) && bus.req;
    assign sel_end = (op_q == OP_MULT) ? bus.mult_end : bus.div_end;

    always_comb begin
        // NOTE: defaults first so no path leaves a comb output unassigned (no latch).
        state_d = state_q;
`ifdef MULDIV_TIMEOUT_EN
        to_timeout = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    // A zero divisor never reaches the divider.
                    state_d = is_div_by_zero(bus.op_sel, bus.b_in == '0) ? S_EXC : S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (op_q == OP_DIV && bus.div_0_exception) begin
                    state_d = S_EXC;
                end else if (sel_end) begin
                    state_d = S_COMMIT;
`ifdef MULDIV_TIMEOUT_EN
                end else if (wd_expire) begin
                    state_d    = S_EXC;
                    to_timeout = 1'b1;
`endif
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_EXC:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_DIV;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            // Operands freeze for the whole operation, whatever a_in/b_in do.
            if (accept) begin
                op_q   <= bus.op_sel;
                op_a_q <= bus.a_in;
                op_b_q <= bus.b_in;
            end
        end
    end

`ifdef MULDIV_TIMEOUT_EN
    // Remembers why EXC was entered; only meaningful during the EXC cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            exc_timeout_q <= 1'b0;
        end else begin
            exc_timeout_q <= to_timeout;
        end
    end

    assign bus.div0_exc = (state_q == S_EXC) && !exc_timeout_q;
    assign bus.timeout  = (state_q == S_EXC) &&  exc_timeout_q;
`else
    assign bus.div0_exc = (state_q == S_EXC);
    assign bus.timeout  = 1'b0;
`endif

    assign bus.ready       = (state_q == S_IDLE);
    assign bus.op_a        = op_a_q;
    assign bus.op_b        = op_b_q;
    assign bus.mult_start  = (state_q == S_START) && (op_q == OP_MULT);
    assign bus.div_start   = (state_q == S_START) && (op_q == OP_DIV);
    // Follows the latched op in every state so the HI/LO mux settles before COMMIT.
    assign bus.div_or_mult = op_q;
    assign bus.high_write  = (state_q == S_COMMIT);
    assign bus.low_write   = (state_q == S_COMMIT);
    assign bus.done        = (state_q == S_COMMIT);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural HI/LO register model.
// Built with MULDIV_TIMEOUT_EN it also exercises the watchdog with TIMEOUT_CYCLES=8.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int DATA_W = 32;
    localparam int TO     = 8;
`ifdef MULDIV_TIMEOUT_EN
    localparam int MULT_LAT = 6;
`else
    localparam int MULT_LAT = 34;
`endif

    logic clock = 1'b0;
    logic reset;

    muldiv_sequencer_if #(.DATA_W(DATA_W)) bus ();

    muldiv_sequencer #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event counters and the HI/LO registers the sequencer writes into.
    int          mult_starts = 0;
    int          div_starts  = 0;
    int          writes      = 0;
    int          dones       = 0;
    int          div0s       = 0;
    int          timeouts    = 0;
    logic [31:0] hi_reg      = '0;
    logic [31:0] lo_reg      = '0;
    logic [63:0] prod;

    assign prod = 64'(bus.op_a) * 64'(bus.op_b);

    always @(negedge clock) begin
        if (bus.mult_start) mult_starts++;
        if (bus.div_start)  div_starts++;
        if (bus.done)       dones++;
        if (bus.div0_exc)   div0s++;
        if (bus.timeout)    timeouts++;
        if (bus.high_write || bus.low_write) writes++;
        if (bus.high_write) hi_reg = bus.div_or_mult ? prod[63:32] : bus.op_a % bus.op_b;
        if (bus.low_write)  lo_reg = bus.div_or_mult ? prod[31:0]  : bus.op_a / bus.op_b;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.req    = 1'b1;
        bus.op_sel = op;
        bus.a_in   = a;
        bus.b_in   = b;
        tick();
        bus.req  = 1'b0;
        bus.a_in = 32'hdead_beef;
        bus.b_in = 32'h1234_5678;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ms0, ds0, w0, d0, z0, t0;

        reset               = 1'b1;
        bus.req             = 1'b0;
        bus.op_sel          = OP_DIV;
        bus.a_in            = '0;
        bus.b_in            = '0;
        bus.mult_end        = 1'b0;
        bus.div_end         = 1'b0;
        bus.div_0_exception = 1'b0;
        tick();
        tick();

        check("rst_ready",      64'(bus.ready),       64'(1));
        check("rst_op_a",       64'(bus.op_a),        64'(0));
        check("rst_op_b",       64'(bus.op_b),        64'(0));
        check("rst_div_or_mult",64'(bus.div_or_mult), 64'(0));
        check("rst_mult_start", 64'(bus.mult_start),  64'(0));
        check("rst_div_start",  64'(bus.div_start),   64'(0));
        check("rst_high_write", 64'(bus.high_write),  64'(0));
        check("rst_low_write",  64'(bus.low_write),   64'(0));
        check("rst_done",       64'(bus.done),        64'(0));
        check("rst_div0_exc",   64'(bus.div0_exc),    64'(0));
        check("rst_timeout",    64'(bus.timeout),     64'(0));
        reset = 1'b0;
        tick();

        // MULT 7 x 6, end MULT_LAT cycles after the start cycle.
        ms0 = mult_starts; ds0 = div_starts; d0 = dones;
        issue(OP_MULT, 32'd7, 32'd6);
        check("mul_start_pulse", 64'(bus.mult_start), 64'(1));
        check("mul_no_div_start",64'(bus.div_start),  64'(0));
        check("mul_ready_low",   64'(bus.ready),      64'(0));
        repeat (MULT_LAT) tick();
        check("mul_op_a_stable", 64'(bus.op_a),       64'(7));
        check("mul_op_b_stable", 64'(bus.op_b),       64'(6));
        check("mul_wait_ready",  64'(bus.ready),      64'(0));
        bus.mult_end = 1'b1;
        tick();
        bus.mult_end = 1'b0;
        check("mul_commit_done", 64'(bus.done),        64'(1));
        check("mul_commit_hw",   64'(bus.high_write),  64'(1));
        check("mul_commit_lw",   64'(bus.low_write),   64'(1));
        check("mul_commit_sel",  64'(bus.div_or_mult), 64'(1));
        tick();
        check("mul_ready_back",  64'(bus.ready),       64'(1));
        check("mul_done_clear",  64'(bus.done),        64'(0));
        check("mul_hi",          64'(hi_reg),          64'(0));
        check("mul_lo",          64'(lo_reg),          64'(42));
        check("mul_start_count", 64'(mult_starts - ms0), 64'(1));
        check("mul_div_starts",  64'(div_starts - ds0),  64'(0));
        check("mul_done_count",  64'(dones - d0),        64'(1));

        // DIV 17 / 5 with a stray mult_end during WAIT.
        ms0 = mult_starts; ds0 = div_starts; d0 = dones;
        issue(OP_DIV, 32'd17, 32'd5);
        check("div_start_pulse", 64'(bus.div_start),  64'(1));
        check("div_no_mul_start",64'(bus.mult_start), 64'(0));
        tick();
        tick();
        bus.mult_end = 1'b1;
        tick();
        bus.mult_end = 1'b0;
        check("div_ignore_mend_ready", 64'(bus.ready), 64'(0));
        check("div_ignore_mend_done",  64'(bus.done),  64'(0));
        tick();
        tick();
        bus.div_end = 1'b1;
        tick();
        bus.div_end = 1'b0;
        check("div_commit_done", 64'(bus.done),        64'(1));
        check("div_commit_sel",  64'(bus.div_or_mult), 64'(0));
        tick();
        check("div_ready_back",  64'(bus.ready),      64'(1));
        check("div_lo",          64'(lo_reg),         64'(3));
        check("div_hi",          64'(hi_reg),         64'(2));
        check("div_start_count", 64'(div_starts - ds0),  64'(1));
        check("div_mul_starts",  64'(mult_starts - ms0), 64'(0));
        check("div_done_count",  64'(dones - d0),        64'(1));

        // DIV 9 / 0 is screened before the divider.
        ds0 = div_starts; w0 = writes; z0 = div0s; d0 = dones;
        issue(OP_DIV, 32'd9, 32'd0);
        check("dz_exc_pulse",    64'(bus.div0_exc),   64'(1));
        check("dz_no_div_start", 64'(bus.div_start),  64'(0));
        check("dz_ready_low",    64'(bus.ready),      64'(0));
        check("dz_no_done",      64'(bus.done),       64'(0));
        tick();
        check("dz_ready_back",   64'(bus.ready),      64'(1));
        check("dz_exc_clear",    64'(bus.div0_exc),   64'(0));
        check("dz_div_starts",   64'(div_starts - ds0), 64'(0));
        check("dz_writes",       64'(writes - w0),      64'(0));
        check("dz_exc_count",    64'(div0s - z0),       64'(1));
        check("dz_done_count",   64'(dones - d0),       64'(0));

        // Divider's own zero flag beats div_end in the same WAIT cycle.
        w0 = writes; z0 = div0s; d0 = dones;
        issue(OP_DIV, 32'd20, 32'd4);
        tick();
        bus.div_0_exception = 1'b1;
        bus.div_end         = 1'b1;
        tick();
        bus.div_0_exception = 1'b0;
        bus.div_end         = 1'b0;
        check("dx_exc_pulse",    64'(bus.div0_exc),   64'(1));
        check("dx_no_hw",        64'(bus.high_write), 64'(0));
        tick();
        check("dx_ready_back",   64'(bus.ready),      64'(1));
        check("dx_writes",       64'(writes - w0),    64'(0));
        check("dx_done_count",   64'(dones - d0),     64'(0));
        check("dx_exc_count",    64'(div0s - z0),     64'(1));

        // Requests while busy are dropped and operands stay frozen.
        ms0 = mult_starts; d0 = dones;
        issue(OP_MULT, 32'd3, 32'd4);
        bus.req  = 1'b1;
        bus.a_in = 32'd99;
        bus.b_in = 32'd77;
        repeat (5) tick();
        check("busy_op_a",       64'(bus.op_a),       64'(3));
        check("busy_op_b",       64'(bus.op_b),       64'(4));
        check("busy_ready",      64'(bus.ready),      64'(0));
        bus.mult_end = 1'b1;
        bus.req      = 1'b0;
        tick();
        bus.mult_end = 1'b0;
        tick();
        tick();
        check("busy_ready_back", 64'(bus.ready),         64'(1));
        check("busy_lo",         64'(lo_reg),            64'(12));
        check("busy_done_count", 64'(dones - d0),        64'(1));
        check("busy_starts",     64'(mult_starts - ms0), 64'(1));

        // Reset in WAIT aborts without commit.
        w0 = writes; d0 = dones;
        issue(OP_MULT, 32'd5, 32'd5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rw_ready",        64'(bus.ready),      64'(1));
        check("rw_op_a",         64'(bus.op_a),       64'(0));
        check("rw_op_b",         64'(bus.op_b),       64'(0));
        check("rw_mult_start",   64'(bus.mult_start), 64'(0));
        check("rw_high_write",   64'(bus.high_write), 64'(0));
        check("rw_done",         64'(bus.done),       64'(0));
        reset        = 1'b0;
        bus.mult_end = 1'b1;
        tick();
        bus.mult_end = 1'b0;
        tick();
        check("rw_writes",       64'(writes - w0),    64'(0));
        check("rw_done_count",   64'(dones - d0),     64'(0));
        check("rw_ready_after",  64'(bus.ready),      64'(1));

`ifdef MULDIV_TIMEOUT_EN
        // No end: timeout after 8 WAIT cycles.
        w0 = writes; t0 = timeouts; d0 = dones;
        issue(OP_MULT, 32'd2, 32'd3);
        tick();
        repeat (TO - 1) tick();
        check("to_wait8_ready",  64'(bus.ready),      64'(0));
        check("to_wait8_nopulse",64'(bus.timeout),    64'(0));
        tick();
        check("to_pulse",        64'(bus.timeout),    64'(1));
        check("to_no_div0",      64'(bus.div0_exc),   64'(0));
        check("to_no_hw",        64'(bus.high_write), 64'(0));
        tick();
        check("to_ready_back",   64'(bus.ready),      64'(1));
        check("to_writes",       64'(writes - w0),    64'(0));
        check("to_count",        64'(timeouts - t0),  64'(1));
        check("to_done_count",   64'(dones - d0),     64'(0));

        // End in the 8th WAIT cycle beats the watchdog.
        t0 = timeouts; d0 = dones;
        issue(OP_MULT, 32'd2, 32'd3);
        tick();
        repeat (TO - 1) tick();
        bus.mult_end = 1'b1;
        tick();
        bus.mult_end = 1'b0;
        check("tw_commit_done",  64'(bus.done),       64'(1));
        check("tw_no_timeout",   64'(bus.timeout),    64'(0));
        tick();
        check("tw_lo",           64'(lo_reg),         64'(6));
        check("tw_to_count",     64'(timeouts - t0),  64'(0));
        check("tw_done_count",   64'(dones - d0),     64'(1));
`else
        t0 = 0;
        check("no_timeout_ever", 64'(timeouts - t0),  64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
